// File: rtl/io_scan_sequencer.sv
// Walking-one IO scanner: advances one pin per tick in walk-up, bounce,
// walk-down or hold mode, and steps an RGB status phase on each full scan.
module io_scan_sequencer #(
    parameter  int NUM_PINS = 20,
    localparam int IDX_W    = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                tick,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_PINS-1:0] pins,
    output logic [IDX_W-1:0]    index,
    output logic                wrap,
    output logic [2:0]          nRgb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PINS - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] ZERO = '0;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [NUM_PINS-1:0]   pins_q, pins_d;
    logic                  wrap_q, wrap_d;
    logic [1:0]            phase_q, phase_d;
    logic [2:0]            nRgb_q, nRgb_d;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    if (mode == 2'd2) begin
                        state_d = S_DOWN;
                        index_d = LAST;
                    end else begin
                        state_d = S_UP;
                        index_d = ZERO;
                    end
                end
            end
            S_UP, S_DOWN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    index_d = ZERO;
                end else if (tick) begin
                    unique case (mode)
                        2'd0: begin
                            state_d = S_UP;
                            if (index_q == LAST) begin
                                index_d = ZERO;
                                wrap_d  = 1'b1;
                            end else begin
                                index_d = index_q + ONE;
                            end
                        end
                        2'd2: begin
                            state_d = S_DOWN;
                            if (index_q == ZERO) begin
                                index_d = LAST;
                                wrap_d  = 1'b1;
                            end else begin
                                index_d = index_q - ONE;
                            end
                        end
                        2'd1: begin
                            // A single pin has nowhere to bounce to
                            if (NUM_PINS == 1) begin
                                wrap_d = 1'b1;
                            end else if (state_q == S_UP) begin
                                if (index_q == LAST) begin
                                    state_d = S_DOWN;
                                    index_d = LAST - ONE;
                                end else begin
                                    index_d = index_q + ONE;
                                end
                            end else begin
                                if (index_q == ZERO) begin
                                    state_d = S_UP;
                                    index_d = ONE;
                                    wrap_d  = 1'b1;
                                end else begin
                                    index_d = index_q - ONE;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                index_d = ZERO;
            end
        endcase
    end

    always_comb begin
        pins_d = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            pins_d[i] = (state_d != S_IDLE) && (index_d == IDX_W'(i));
        end
        phase_d = wrap_d ? phase_q + 2'd1 : phase_q;
        nRgb_d  = ~{phase_d == 2'd3, phase_d == 2'd2, phase_d == 2'd1};
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            index_q <= '0;
            pins_q  <= '0;
            wrap_q  <= 1'b0;
            phase_q <= 2'd0;
            nRgb_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            pins_q  <= pins_d;
            wrap_q  <= wrap_d;
            phase_q <= phase_d;
            nRgb_q  <= nRgb_d;
        end
    end

    assign pins  = pins_q;
    assign index = index_q;
    assign wrap  = wrap_q;
    assign nRgb  = nRgb_q;

endmodule

// File: tb/tb_io_scan_sequencer.sv
// Directed bench for io_scan_sequencer: 20-pin scanner plus 1- and
// 2-pin corner instances sharing the same stimulus.
module tb_io_scan_sequencer;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        tick = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic [19:0] pins20;
    logic [4:0]  index20;
    logic        wrap20;
    logic [2:0]  nRgb20;
    logic [0:0]  pins1;
    logic [0:0]  index1;
    logic        wrap1;
    logic [2:0]  nRgb1;
    logic [1:0]  pins2;
    logic [0:0]  index2;
    logic        wrap2;
    logic [2:0]  nRgb2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    io_scan_sequencer #(.NUM_PINS(20)) dut20 (
        .clk(clk), .nRst(nRst), .tick(tick), .enable(enable), .mode(mode),
        .pins(pins20), .index(index20), .wrap(wrap20), .nRgb(nRgb20)
    );

    io_scan_sequencer #(.NUM_PINS(1)) dut1 (
        .clk(clk), .nRst(nRst), .tick(tick), .enable(enable), .mode(mode),
        .pins(pins1), .index(index1), .wrap(wrap1), .nRgb(nRgb1)
    );

    io_scan_sequencer #(.NUM_PINS(2)) dut2 (
        .clk(clk), .nRst(nRst), .tick(tick), .enable(enable), .mode(mode),
        .pins(pins2), .index(index2), .wrap(wrap2), .nRgb(nRgb2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses tick for one clk; returns at the negedge after it was sampled.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic idle_clk();
        @(negedge clk);
    endtask

    task automatic chk20(input string tag, input int idx, input logic w);
        chk({tag, ".index"}, 32'(index20), 32'(idx));
        chk({tag, ".pins"}, 32'(pins20), 32'(1) << idx);
        chk({tag, ".wrap"}, 32'(wrap20), 32'(w));
    endtask

    initial begin
        int exp_idx;
        // Reset state
        #12;
        chk("rst.index", 32'(index20), 0);
        chk("rst.pins", 32'(pins20), 0);
        chk("rst.wrap", 32'(wrap20), 0);
        chk("rst.nRgb", 32'(nRgb20), 32'h7);
        @(negedge clk);
        nRst = 1'b1;

        // Ticks without enable stay idle
        do_tick();
        chk("idle.pins", 32'(pins20), 0);
        chk("idle.index", 32'(index20), 0);

        // Test 1: walk-up, 21 ticks
        enable = 1'b1;
        mode = 2'd0;
        for (int k = 0; k < 21; k++) begin
            do_tick();
            chk20("t1", (k < 20) ? k : 0, k == 20);
        end
        chk("t1.nRgb", 32'(nRgb20), 32'h6);
        idle_clk();
        chk("t1.wrap_low", 32'(wrap20), 0);

        // Test 2: bounce, 40 ticks from entry (phase kept at 1)
        enable = 1'b0;
        idle_clk();
        chk("t2.idle_pins", 32'(pins20), 0);
        enable = 1'b1;
        mode = 2'd1;
        for (int k = 0; k < 40; k++) begin
            if (k < 20) exp_idx = k;
            else if (k < 39) exp_idx = 38 - k;
            else exp_idx = 1;
            do_tick();
            chk20("t2", exp_idx, k == 39);
        end
        chk("t2.nRgb", 32'(nRgb20), 32'h5);

        // Test 3: walk-down from reset, four full scans
        nRst = 1'b0;
        #2;
        nRst = 1'b1;
        mode = 2'd2;
        for (int k = 0; k <= 80; k++) begin
            do_tick();
            chk20("t3", 19 - (k % 20), (k > 0) && (k % 20 == 0));
            if (k == 20) chk("t3.nRgb1", 32'(nRgb20), 32'h6);
            if (k == 40) chk("t3.nRgb2", 32'(nRgb20), 32'h5);
            if (k == 60) chk("t3.nRgb3", 32'(nRgb20), 32'h3);
            if (k == 80) chk("t3.nRgb0", 32'(nRgb20), 32'h7);
        end

        // Test 4: switch to walk-up mid-scan, drop enable at 7
        mode = 2'd0;
        do_tick();
        chk20("t4.turn", 0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            do_tick();
            chk20("t4", k, 1'b0);
        end
        enable = 1'b0;
        idle_clk();
        chk("t4.off_pins", 32'(pins20), 0);
        chk("t4.off_index", 32'(index20), 0);
        chk("t4.off_wrap", 32'(wrap20), 0);
        enable = 1'b1;
        do_tick();
        chk20("t4.restart", 0, 1'b0);

        // Test 5: hold at 5, then async reset at 12
        for (int k = 1; k <= 5; k++) do_tick();
        chk20("t5.at5", 5, 1'b0);
        mode = 2'd3;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            chk20("t5.hold", 5, 1'b0);
        end
        mode = 2'd0;
        do_tick();
        chk20("t5.resume", 6, 1'b0);
        for (int k = 7; k <= 12; k++) do_tick();
        chk20("t5.at12", 12, 1'b0);
        chk("t5.nRgb_pre", 32'(nRgb20), 32'h6);
        #2;
        nRst = 1'b0;
        #1;
        chk("t5.rst_pins", 32'(pins20), 0);
        chk("t5.rst_index", 32'(index20), 0);
        chk("t5.rst_nRgb", 32'(nRgb20), 32'h7);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("t5.rst_tick", 32'(index20), 0);
        nRst = 1'b1;
        idle_clk();
        chk("t5.post_pins", 32'(pins20), 0);

        // Test 6a: single pin, walk-up (all instances were reset above)
        do_tick();
        chk("t6.n1_pins", 32'(pins1), 1);
        chk("t6.n1_index", 32'(index1), 0);
        chk("t6.n1_wrap0", 32'(wrap1), 0);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            chk("t6.n1_wrap", 32'(wrap1), 1);
            chk("t6.n1_pins_run", 32'(pins1), 1);
        end
        idle_clk();
        chk("t6.n1_nowrap", 32'(wrap1), 0);
        chk("t6.n1_nRgb", 32'(nRgb1), 32'h3);

        // Test 6b: two pins, bounce; single pin keeps wrapping
        enable = 1'b0;
        idle_clk();
        enable = 1'b1;
        mode = 2'd1;
        do_tick();
        chk("t6.n2_entry", 32'(index2), 0);
        chk("t6.n2_entry_wrap", 32'(wrap2), 0);
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            chk("t6.n2_index", 32'(index2), 32'(k % 2));
            chk("t6.n2_pins", 32'(pins2), (k % 2 == 1) ? 2 : 1);
            chk("t6.n2_wrap", 32'(wrap2), 32'((k == 3) || (k == 5)));
            chk("t6.n1_bounce_idx", 32'(index1), 0);
            chk("t6.n1_bounce_wrap", 32'(wrap1), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
